dac_frame_sequencer: RTL and testbench
======================================

# dac_frame_sequencer

Per-sample controller for the heart-rate signal chain. On each captured ADC sample it starts the FIR filter, waits for the filtered result, enables the peak detector for one cycle, then serializes the filtered value to the external serial DAC with correctly timed `dac_clk`, `dac_load` and `dac_ldac`. It sits between the SPI sample capture and the filter, peak-finder and DAC pins. It replaces the free-running per-module 16-count frame counters with one explicit sequencer in the `clk` domain.

## Interface
Parameters:
- `DATA_W`, 10, sample and filtered-sample width.
- `CLK_DIV`, 4, `clk` cycles per `dac_clk` half-period. Legal range is 1..255.
- `FILT_TIMEOUT`, 64, maximum number of `WAIT_FILT` cycles before the frame is abandoned.

Ports:
- `clk` input 1: the single clock.
- `reset` input 1: synchronous, active-low reset.
- `sample_valid` input 1: one-cycle strobe, new raw sample present.
- `sample` input `DATA_W`: raw sample, qualified by `sample_valid`.
- `filt_start` output 1: one-cycle pulse, starts the filter on the latched sample.
- `filt_done` input 1: one-cycle strobe, `filt_data` is valid.
- `filt_data` input `DATA_W`: filtered sample.
- `peak_en` output 1: one-cycle advance strobe for the peak detector.
- `dac_data` output 1: serial DAC data, MSB first.
- `dac_clk` output 1: serial DAC clock. The DAC latches on the falling edge.
- `dac_load` output 1: active-low DAC load strobe.
- `dac_ldac` output 1: held at constant 0.
- `busy` output 1: high in any state other than `IDLE`.
- `overrun` output 1: one-cycle pulse when a sample is dropped.
- `filt_timeout` output 1: one-cycle pulse when the frame is abandoned.

## Operation
- States: `IDLE`, `WAIT_FILT`, `SHIFT`, `LOAD`. With `DAC_DUAL_CH_EN`, `SHIFT` and `LOAD` are run a second time for channel B.
- `IDLE`: when `sample_valid` is high, latch `sample` into `raw_q`, pulse `filt_start` and go to `WAIT_FILT`.
- `WAIT_FILT`:
  - On `filt_done`, latch `filt_data` into `filt_q`, pulse `peak_en`, load the shift word and go to `SHIFT`.
  - The timeout counter counts cycles spent in this state. If it reaches `FILT_TIMEOUT` with no `filt_done`, pulse `filt_timeout` and go to `IDLE`.
- DAC word (11 bits) = {A[1:0]=2'b00, RNG=0, `filt_q[DATA_W-1:DATA_W-8]`}, sent MSB first.
- `SHIFT`, per bit:
  - `dac_data` updates and `dac_clk` goes high for `CLK_DIV` cycles.
  - `dac_clk` then goes low for `CLK_DIV` cycles.
  - After 11 bits, go to `LOAD`.
- `LOAD`: `dac_load` is 0 for `CLK_DIV` cycles, then returns to 1. Go to `IDLE`.
- `sample_valid` while `busy` is high: the sample is dropped and `overrun` pulses. The exception is the final `LOAD` cycle: `sample_valid` there is accepted exactly as in `IDLE`, and the state goes straight to `WAIT_FILT`.
- `filt_done` outside `WAIT_FILT` is ignored.
- `sample` and `filt_data` are not observed outside their strobes. `raw_q` and `filt_q` are stable for the whole frame.
- `reset=0` at any cycle, including mid-`SHIFT`, forces the idle values on the next edge. The partial DAC word is discarded and no `dac_load` is issued.

## Timing
- Reset and idle output values: `filt_start`=0, `peak_en`=0, `dac_data`=0, `dac_clk`=0, `dac_load`=1, `dac_ldac`=0, `busy`=0, `overrun`=0, `filt_timeout`=0.
- All outputs are registered. There is no combinational input-to-output path.
- `sample_valid` at cycle N: `filt_start` and `busy` go high at N+1.
- `filt_done` at cycle M:
  - `peak_en`=1, `dac_clk`=1 and `dac_data`=word[10], all at M+1.
  - First falling edge at M+1+`CLK_DIV`.
- `SHIFT` lasts 22·`CLK_DIV` cycles. `LOAD` lasts `CLK_DIV` cycles.
- `busy` falls on the cycle after `LOAD` ends.
- Timeout: `filt_start` at cycle T with no `filt_done` gives `filt_timeout` at T+`FILT_TIMEOUT`, with `busy`=0 on the same cycle.
- The timeout counter is wide enough for `FILT_TIMEOUT` and never wraps.

## Configuration
- `DAC_DUAL_CH_EN` defined:
  - After channel A `LOAD`, a second `SHIFT`/`LOAD` sends {2'b01, 0, `raw_q[DATA_W-1:DATA_W-8]`} on channel B.
  - The last-`LOAD` accept rule applies only to the channel B `LOAD`.
- Undefined: channel A only, and no channel-B logic is synthesized.

## Structure
- Package `hr_pkg` holds:
  - The state enum.
  - `DAC_WORD_W`=11.
  - The channel codes `DAC_CH_A`=2'b00 and `DAC_CH_B`=2'b01.
  - `DAC_RNG`=1'b0.
- Sub-module `dac_bit_timer`:
  - Counts `CLK_DIV` cycles and emits a half-period tick.
  - Cleared on `reset` and on entry to `SHIFT`/`LOAD`.
  - The sequencer uses it for both `SHIFT` and `LOAD` timing.

## Test plan
All tests use `CLK_DIV`=2 and `FILT_TIMEOUT`=16.
- Reset: `reset`=0 for 3 cycles while `sample_valid`=1. Outputs hold idle values and `filt_start` never pulses.
- Nominal frame:
  - Stimulus: `sample`=10'h3FC, then `filt_done` 5 cycles after `filt_start` with `filt_data`=10'h2A5.
  - `peak_en` is a single pulse.
  - The 11 falling edges capture 000_10101001, one bit every 4 cycles.
  - `dac_load` is 0 for 2 cycles.
  - `busy` is high for 1+5+44+2 cycles.
- Overrun: `sample_valid` during `SHIFT`. `overrun` pulses once and the serial word is unchanged. A `sample_valid` on the last `LOAD` cycle gives `filt_start` on the next cycle.
- Timeout: no `filt_done`. `filt_timeout` fires 16 cycles after `filt_start`, and `dac_clk` stays 0.
- Reset mid-operation: `reset`=0 at bit 5 of `SHIFT`. Next cycle `dac_clk`=0, `dac_load`=1, `busy`=0. A following sample completes a full frame.
- `DAC_DUAL_CH_EN` with raw sample 10'h3FC: a second word 010_11111111 follows the channel A `LOAD`, with its own 2-cycle `dac_load` low.

Source files
------------

// File: rtl/hr_pkg.sv
// hr_pkg: sequencer states and serial DAC word layout shared by the heart-rate chain.
package hr_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_FILT, SHIFT, LOAD} state_t;
    localparam int DAC_WORD_W = 11;
    localparam logic [1:0] DAC_CH_A = 2'b00;
    localparam logic [1:0] DAC_CH_B = 2'b01;
    localparam logic DAC_RNG = 1'b0;
    function automatic logic [DAC_WORD_W-1:0] dac_word(input logic [1:0] ch, input logic [7:0] code);
        return {ch, DAC_RNG, code};
    endfunction
endpackage

// File: rtl/dac_bit_timer.sv
// dac_bit_timer: counts CLK_DIV cycles and ticks on the last cycle of each dac_clk half-period.
module dac_bit_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    logic [7:0] cnt_q, cnt_d;
    always_comb begin
        tick  = cnt_q == 8'(CLK_DIV - 1);
        cnt_d = (clr || tick) ? 8'd0 : cnt_q + 8'd1;
    end
    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= 8'd0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/dac_frame_sequencer.sv
// dac_frame_sequencer: per-sample FIR start, peak strobe and serial DAC frame.
// Define DAC_DUAL_CH_EN to follow each channel A word with the raw sample on channel B.
module dac_frame_sequencer
    import hr_pkg::*;
#(
    parameter int DATA_W       = 10,
    parameter int CLK_DIV      = 4,
    parameter int FILT_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic              filt_start,
    input  logic              filt_done,
    input  logic [DATA_W-1:0] filt_data,
    output logic              peak_en,
    output logic              dac_data,
    output logic              dac_clk,
    output logic              dac_load,
    output logic              dac_ldac,
    output logic              busy,
    output logic              overrun,
    output logic              filt_timeout
);
    localparam int TW = $clog2(FILT_TIMEOUT + 1);
    state_t state_q, state_d;
    logic [DATA_W-1:0] raw_q, raw_d, filt_q, filt_d;
    logic [TW-1:0] wait_q, wait_d;
    logic [3:0] bit_q, bit_d, nxt_idx;
    logic low_q, low_d;
    logic filt_start_q, filt_start_d, peak_en_q, peak_en_d;
    logic dac_data_q, dac_data_d, dac_clk_q, dac_clk_d, dac_load_q, dac_load_d;
    logic busy_q, busy_d, overrun_q, overrun_d, filt_timeout_q, filt_timeout_d;
    logic tick, tmr_clr, accept, ch_b_q, unused_lsbs;
    logic [DAC_WORD_W-1:0] word;
`ifdef DAC_DUAL_CH_EN
    logic ch_b_d;
    always_ff @(posedge clk) begin
        if (!reset) ch_b_q <= 1'b0;
        else        ch_b_q <= ch_b_d;
    end
`else
    assign ch_b_q = 1'b0;
`endif
    dac_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (tmr_clr),
        .tick  (tick)
    );
    // Word bits are picked straight out of the latched samples, which stay put for the frame.
    assign word    = ch_b_q ? dac_word(DAC_CH_B, raw_q[DATA_W-1 -: 8]) : dac_word(DAC_CH_A, filt_q[DATA_W-1 -: 8]);
    assign nxt_idx = 4'(DAC_WORD_W - 2) - bit_q;
    assign unused_lsbs = ^{raw_q, filt_q};
    always_comb begin
        state_d        = state_q;
        raw_d          = raw_q;
        filt_d         = filt_q;
        wait_d         = '0;
        bit_d          = bit_q;
        low_d          = low_q;
        filt_start_d   = 1'b0;
        peak_en_d      = 1'b0;
        dac_data_d     = dac_data_q;
        dac_clk_d      = dac_clk_q;
        dac_load_d     = 1'b1;
        filt_timeout_d = 1'b0;
        tmr_clr        = 1'b0;
        accept         = 1'b0;
`ifdef DAC_DUAL_CH_EN
        ch_b_d         = ch_b_q;
`endif
        case (state_q)
            IDLE: accept = sample_valid;
            WAIT_FILT: begin
                wait_d = wait_q + 1'b1;
                if (filt_done) begin
                    filt_d     = filt_data;
                    peak_en_d  = 1'b1;
                    state_d    = SHIFT;
                    bit_d      = 4'd0;
                    low_d      = 1'b0;
                    dac_clk_d  = 1'b1;
                    dac_data_d = DAC_CH_A[1];
                    tmr_clr    = 1'b1;
`ifdef DAC_DUAL_CH_EN
                    ch_b_d     = 1'b0;
`endif
                end else if (wait_q == TW'(FILT_TIMEOUT - 1)) begin
                    filt_timeout_d = 1'b1;
                    state_d        = IDLE;
                end
            end
            SHIFT: begin
                if (tick && !low_q) begin
                    dac_clk_d = 1'b0;
                    low_d     = 1'b1;
                end else if (tick && bit_q == 4'(DAC_WORD_W - 1)) begin
                    state_d    = LOAD;
                    dac_load_d = 1'b0;
                    dac_data_d = 1'b0;
                    tmr_clr    = 1'b1;
                end else if (tick) begin
                    bit_d      = bit_q + 4'd1;
                    low_d      = 1'b0;
                    dac_clk_d  = 1'b1;
                    dac_data_d = word[nxt_idx];
                end
            end
            LOAD: begin
                dac_load_d = tick;
                if (tick) begin
`ifdef DAC_DUAL_CH_EN
                    if (!ch_b_q) begin
                        state_d    = SHIFT;
                        ch_b_d     = 1'b1;
                        bit_d      = 4'd0;
                        low_d      = 1'b0;
                        dac_clk_d  = 1'b1;
                        dac_data_d = DAC_CH_B[1];
                        tmr_clr    = 1'b1;
                    end else begin
                        state_d = IDLE;
                        accept  = sample_valid;
                    end
`else
                    state_d = IDLE;
                    accept  = sample_valid;
`endif
                end
            end
        endcase
        if (accept) begin
            raw_d        = sample;
            filt_start_d = 1'b1;
            state_d      = WAIT_FILT;
        end
        overrun_d = sample_valid && state_q != IDLE && !accept;
        busy_d    = state_d != IDLE;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            raw_q          <= '0;
            filt_q         <= '0;
            wait_q         <= '0;
            bit_q          <= 4'd0;
            low_q          <= 1'b0;
            filt_start_q   <= 1'b0;
            peak_en_q      <= 1'b0;
            dac_data_q     <= 1'b0;
            dac_clk_q      <= 1'b0;
            dac_load_q     <= 1'b1;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
            filt_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            raw_q          <= raw_d;
            filt_q         <= filt_d;
            wait_q         <= wait_d;
            bit_q          <= bit_d;
            low_q          <= low_d;
            filt_start_q   <= filt_start_d;
            peak_en_q      <= peak_en_d;
            dac_data_q     <= dac_data_d;
            dac_clk_q      <= dac_clk_d;
            dac_load_q     <= dac_load_d;
            busy_q         <= busy_d;
            overrun_q      <= overrun_d;
            filt_timeout_q <= filt_timeout_d;
        end
    end
    assign filt_start   = filt_start_q;
    assign peak_en      = peak_en_q;
    assign dac_data     = dac_data_q;
    assign dac_clk      = dac_clk_q;
    assign dac_load     = dac_load_q;
    assign dac_ldac     = 1'b0;
    assign busy         = busy_q;
    assign overrun      = overrun_q;
    assign filt_timeout = filt_timeout_q;
endmodule

// File: tb/tb_dac_frame_sequencer.sv
// tb_dac_frame_sequencer: randomized frames checked against a timing/word model of the sequencer.
module tb_dac_frame_sequencer;
    localparam int DW = 10;
    localparam int CD = 2;
    localparam int FT = 16;
`ifdef DAC_DUAL_CH_EN
    localparam int NW = 2;
`else
    localparam int NW = 1;
`endif
    localparam int FRAME = 23 * CD * NW;
    localparam logic [8:0] IDLE_V = 9'b000010000;

    logic clk = 1'b0, reset = 1'b0, sample_valid = 1'b0, filt_done = 1'b0;
    logic [DW-1:0] sample = '0, filt_data = '0;
    logic filt_start, peak_en, dac_data, dac_clk, dac_load, dac_ldac, busy, overrun, filt_timeout;
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    dac_frame_sequencer #(.DATA_W(DW), .CLK_DIV(CD), .FILT_TIMEOUT(FT)) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
        .filt_start(filt_start), .filt_done(filt_done), .filt_data(filt_data),
        .peak_en(peak_en), .dac_data(dac_data), .dac_clk(dac_clk), .dac_load(dac_load),
        .dac_ldac(dac_ldac), .busy(busy), .overrun(overrun), .filt_timeout(filt_timeout)
    );

    // Observation of the DAC pins and strobes, sampled mid-cycle.
    int cyc = 0, load_n = 0, busy_n = 0, hi_n = 0, ovr_n = 0, tout_n = 0, fs_n = 0, ldac_n = 0;
    int fall_cyc[$], peak_cyc[$];
    logic fall_bit[$];
    logic prev_clk = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (prev_clk && !dac_clk) begin
            fall_cyc.push_back(cyc);
            fall_bit.push_back(dac_data);
        end
        if (peak_en) peak_cyc.push_back(cyc);
        if (!dac_load) load_n++;
        if (busy) busy_n++;
        if (dac_clk) hi_n++;
        if (overrun) ovr_n++;
        if (filt_timeout) tout_n++;
        if (filt_start) fs_n++;
        if (dac_ldac !== 1'b0) ldac_n++;
        prev_clk = dac_clk;
    end

    function automatic logic [10:0] word_of(input logic [1:0] ch, input logic [DW-1:0] v);
        return {ch, 1'b0, v[DW-1 -: 8]};
    endfunction

    function automatic logic [10:0] got_word(input int base);
        logic [10:0] w = 'x;
        for (int i = 0; i < 11; i++)
            w = {w[9:0], (base + i < fall_bit.size()) ? fall_bit[base + i] : 1'bx};
        return w;
    endfunction

    function automatic int bad_gaps();
        int n = 0;
        for (int w = 0; w < NW; w++)
            for (int i = 0; i < 10; i++)
                if (11 * w + i + 1 >= fall_cyc.size() || fall_cyc[11*w+i+1] - fall_cyc[11*w+i] != 2 * CD) n++;
        return n;
    endfunction

    function automatic int first_fall_lag();
        if (fall_cyc.size() == 0 || peak_cyc.size() == 0) return -1;
        return fall_cyc[0] - peak_cyc[0];
    endfunction

    task automatic clear_mon();
        load_n = 0; busy_n = 0; hi_n = 0; ovr_n = 0; tout_n = 0; fs_n = 0; ldac_n = 0;
        fall_cyc.delete(); peak_cyc.delete(); fall_bit.delete();
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (!sample_valid) sample = DW'($urandom);
            if (!filt_done) filt_data = DW'($urandom);
        end
    endtask

    task automatic start_sample(input logic [DW-1:0] s);
        sample_valid = 1'b1; sample = s; step(1); sample_valid = 1'b0;
    endtask

    task automatic give_filt(input logic [DW-1:0] f);
        filt_done = 1'b1; filt_data = f; step(1); filt_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; sample_valid = 1'b1; sample = 10'h155;
        for (int i = 0; i < 3; i++) begin
            step(1);
            n_cmp++;
            if ({filt_start, peak_en, dac_data, dac_clk, dac_load, dac_ldac, busy, overrun, filt_timeout} !== IDLE_V) begin
                n_err++;
                $display("FAIL reset_idle[%0d] got %b want %b", i, {filt_start, peak_en, dac_data, dac_clk, dac_load, dac_ldac, busy, overrun, filt_timeout}, IDLE_V);
            end
        end
        reset = 1'b1; sample_valid = 1'b0;
        step(2);
        n_cmp++;
        if ({filt_start, busy, dac_load} !== 3'b001) begin
            n_err++;
            $display("FAIL reset_release got %b want 001", {filt_start, busy, dac_load});
        end
    endtask

    task automatic test_nominal();
        logic [DW-1:0] s = 10'h3FC, f = 10'h2A5;
        logic [10:0] exp_w;
        clear_mon();
        start_sample(s);
        n_cmp++;
        if ({filt_start, busy} !== 2'b11) begin n_err++; $display("FAIL nom_start got %b want 11", {filt_start, busy}); end
        step(5);
        give_filt(f);
        exp_w = word_of(2'b00, f);
        n_cmp++;
        if ({peak_en, dac_clk, dac_data} !== {2'b11, exp_w[10]}) begin
            n_err++; $display("FAIL nom_first_bit got %b want %b", {peak_en, dac_clk, dac_data}, {2'b11, exp_w[10]});
        end
        step(FRAME + 2);
        for (int w = 0; w < NW; w++) begin
            exp_w = (w == 0) ? word_of(2'b00, f) : word_of(2'b01, s);
            n_cmp++;
            if (got_word(11 * w) !== exp_w) begin n_err++; $display("FAIL nom_word%0d got %b want %b", w, got_word(11 * w), exp_w); end
        end
        n_cmp++;
        if (fall_cyc.size() != 11 * NW) begin n_err++; $display("FAIL nom_falls got %0d want %0d", fall_cyc.size(), 11 * NW); end
        n_cmp++;
        if (bad_gaps() != 0) begin n_err++; $display("FAIL nom_bit_spacing got %0d bad gaps want 0", bad_gaps()); end
        n_cmp++;
        if (first_fall_lag() != CD) begin n_err++; $display("FAIL nom_first_fall got %0d want %0d", first_fall_lag(), CD); end
        n_cmp++;
        if (peak_cyc.size() != 1) begin n_err++; $display("FAIL nom_peak got %0d pulses want 1", peak_cyc.size()); end
        n_cmp++;
        if (load_n != CD * NW) begin n_err++; $display("FAIL nom_load got %0d want %0d", load_n, CD * NW); end
        n_cmp++;
        if (busy_n != 1 + 5 + FRAME) begin n_err++; $display("FAIL nom_busy got %0d want %0d", busy_n, 1 + 5 + FRAME); end
        n_cmp++;
        if (ldac_n != 0 || ovr_n != 0) begin n_err++; $display("FAIL nom_ldac_ovr got %0d/%0d want 0/0", ldac_n, ovr_n); end
    endtask

    task automatic test_random();
        logic [DW-1:0] s, f;
        logic [10:0] exp_w;
        int d;
        for (int k = 0; k < 12; k++) begin
            s = DW'($urandom); f = DW'($urandom); d = int'($urandom_range(0, 12));
            clear_mon();
            start_sample(s);
            step(d);
            give_filt(f);
            step(FRAME + 1 + int'($urandom_range(0, 3)));
            for (int w = 0; w < NW; w++) begin
                exp_w = (w == 0) ? word_of(2'b00, f) : word_of(2'b01, s);
                n_cmp++;
                if (got_word(11 * w) !== exp_w) begin n_err++; $display("FAIL rand%0d_word%0d got %b want %b", k, w, got_word(11 * w), exp_w); end
            end
            n_cmp++;
            if (busy_n != 1 + d + FRAME || peak_cyc.size() != 1 || load_n != CD * NW) begin
                n_err++;
                $display("FAIL rand%0d_timing busy/peak/load got %0d/%0d/%0d want %0d/1/%0d", k, busy_n, peak_cyc.size(), load_n, 1 + d + FRAME, CD * NW);
            end
        end
    endtask

    task automatic test_overrun();
        logic [DW-1:0] s1 = DW'($urandom), f1 = DW'($urandom), s2 = DW'($urandom), f2 = DW'($urandom);
        logic [10:0] exp_w;
        clear_mon();
        start_sample(s1);
        step(3);
        give_filt(f1);
        step(8);
        sample_valid = 1'b1; sample = ~s1; filt_done = 1'b1; filt_data = ~f1;
        step(1);
        sample_valid = 1'b0; filt_done = 1'b0;
        step(FRAME - 10);
        n_cmp++;
        if (dac_load !== 1'b0) begin n_err++; $display("FAIL ovr_last_load got dac_load=%b want 0", dac_load); end
        start_sample(s2);
        n_cmp++;
        if ({filt_start, busy} !== 2'b11) begin n_err++; $display("FAIL ovr_accept got %b want 11", {filt_start, busy}); end
        n_cmp++;
        if (ovr_n != 1) begin n_err++; $display("FAIL ovr_count got %0d want 1", ovr_n); end
        n_cmp++;
        if (peak_cyc.size() != 1) begin n_err++; $display("FAIL ovr_peak got %0d want 1", peak_cyc.size()); end
        for (int w = 0; w < NW; w++) begin
            exp_w = (w == 0) ? word_of(2'b00, f1) : word_of(2'b01, s1);
            n_cmp++;
            if (got_word(11 * w) !== exp_w) begin n_err++; $display("FAIL ovr_word%0d got %b want %b", w, got_word(11 * w), exp_w); end
        end
        clear_mon();
        step(2);
        give_filt(f2);
        step(FRAME + 2);
        exp_w = word_of(2'b00, f2);
        n_cmp++;
        if (got_word(0) !== exp_w) begin n_err++; $display("FAIL ovr_next_word got %b want %b", got_word(0), exp_w); end
        n_cmp++;
        if (busy_n != 1 + 2 + FRAME || ovr_n != 0) begin
            n_err++; $display("FAIL ovr_next_busy busy/ovr got %0d/%0d want %0d/0", busy_n, ovr_n, 1 + 2 + FRAME);
        end
    endtask

    task automatic test_timeout();
        clear_mon();
        start_sample(DW'($urandom));
        step(FT - 1);
        n_cmp++;
        if ({filt_timeout, busy} !== 2'b01) begin n_err++; $display("FAIL tout_early got %b want 01", {filt_timeout, busy}); end
        step(1);
        n_cmp++;
        if ({filt_timeout, busy} !== 2'b10) begin n_err++; $display("FAIL tout_fire got %b want 10", {filt_timeout, busy}); end
        step(2);
        give_filt(DW'($urandom));
        step(4);
        n_cmp++;
        if (hi_n != 0 || tout_n != 1 || peak_cyc.size() != 0 || busy_n != FT) begin
            n_err++;
            $display("FAIL tout_after clk_hi/tout/peak/busy got %0d/%0d/%0d/%0d want 0/1/0/%0d", hi_n, tout_n, peak_cyc.size(), busy_n, FT);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] s = DW'($urandom), f = DW'($urandom);
        logic [10:0] exp_w;
        clear_mon();
        start_sample(DW'($urandom));
        step(2);
        give_filt(DW'($urandom));
        step(10 * CD);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        n_cmp++;
        if ({dac_clk, dac_load, busy} !== 3'b010) begin n_err++; $display("FAIL rmid_idle got %b want 010", {dac_clk, dac_load, busy}); end
        step(FRAME);
        n_cmp++;
        if (load_n != 0 || busy !== 1'b0) begin n_err++; $display("FAIL rmid_no_load load/busy got %0d/%b want 0/0", load_n, busy); end
        clear_mon();
        start_sample(s);
        step(4);
        give_filt(f);
        step(FRAME + 2);
        for (int w = 0; w < NW; w++) begin
            exp_w = (w == 0) ? word_of(2'b00, f) : word_of(2'b01, s);
            n_cmp++;
            if (got_word(11 * w) !== exp_w) begin n_err++; $display("FAIL rmid_word%0d got %b want %b", w, got_word(11 * w), exp_w); end
        end
        n_cmp++;
        if (load_n != CD * NW || busy_n != 1 + 4 + FRAME) begin
            n_err++; $display("FAIL rmid_frame load/busy got %0d/%0d want %0d/%0d", load_n, busy_n, CD * NW, 1 + 4 + FRAME);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_random();
        test_overrun();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
